// File: rtl/wb_port_arbiter_if.sv
// Bundle between the two writeback requesters (ALU, MEM) and the
// register-file write port driven by wb_port_arbiter.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  // Handshake: a beat transfers on the rising edge where x_valid & x_ready.
  // x_ready never depends on x_valid; a source holds valid/addr/data
  // stable until the transfer edge.
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              wb_w;
  logic              wb_sel;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [7:0]        stall_cnt;
  logic [1:0]        dbg_state;

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, wb_w, wb_sel, wb_addr, wb_data, stall_cnt,
           dbg_state
  );

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, wb_w, wb_sel, wb_addr, wb_data, stall_cnt,
           dbg_state
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two 1-entry holding buffers (ALU, MEM) sharing
// one register-file write port, round-robin with an age override on WAW.
module wb_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input logic           sysclk,
  input logic           reset_n,
  wb_port_arbiter_if.slave bus
);
  // State bits are {alu_full, mem_full}.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MEM_ONLY = 2'b01,
    ALU_ONLY = 2'b10,
    BOTH     = 2'b11
  } state_e;

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] alu_addr_q, alu_addr_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d, mem_data_q, mem_data_d;
  logic              mem_older_q, mem_older_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        stall_q, stall_d;
  logic              wb_w_q, wb_w_d, wb_sel_q, wb_sel_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic alu_grant, mem_grant, alu_ready, mem_ready, alu_acc, mem_acc;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      alu_addr_q   <= '0;
      alu_data_q   <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_older_q  <= 1'b0;
      last_grant_q <= GRANT_ALU;
      stall_q      <= '0;
      wb_w_q       <= 1'b0;
      wb_sel_q     <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      alu_addr_q   <= alu_addr_d;
      alu_data_q   <= alu_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_older_q  <= mem_older_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      wb_w_q       <= wb_w_d;
      wb_sel_q     <= wb_sel_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
    end
  end

  always_comb begin
    alu_acc     = bus.alu_valid & alu_ready;
    mem_acc     = bus.mem_valid & mem_ready;
    state_d     = state_e'({alu_acc | (state_q[1] & ~alu_grant),
                            mem_acc | (state_q[0] & ~mem_grant)});
    alu_addr_d  = alu_acc ? bus.alu_addr : alu_addr_q;
    alu_data_d  = alu_acc ? bus.alu_data : alu_data_q;
    mem_addr_d  = mem_acc ? bus.mem_addr : mem_addr_q;
    mem_data_d  = mem_acc ? bus.mem_data : mem_data_q;
    // ALU is older only if it sits through this edge while MEM (re)loads;
    // any same-edge fill leaves MEM as the earlier instruction.
    mem_older_d = ~(state_q[1] & ~alu_grant);
    last_grant_d = last_grant_q;
    if (alu_grant) last_grant_d = GRANT_ALU;
    if (mem_grant) last_grant_d = GRANT_MEM;
    stall_d = stall_q;
    if (state_q == BOTH && stall_q != 8'hFF) stall_d = stall_q + 8'd1;
    wb_w_d    = alu_grant | mem_grant;
    wb_sel_d  = wb_sel_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (alu_grant) begin
      wb_sel_d  = 1'b0;
      wb_addr_d = alu_addr_q;
      wb_data_d = alu_data_q;
    end
    if (mem_grant) begin
      wb_sel_d  = 1'b1;
      wb_addr_d = mem_addr_q;
      wb_data_d = mem_data_q;
    end
  end

  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    case (state_q)
      ALU_ONLY: alu_grant = 1'b1;
      MEM_ONLY: mem_grant = 1'b1;
      BOTH: begin
        // Same destination: the older write must land first.
        if (alu_addr_q == mem_addr_q) begin
          mem_grant = mem_older_q;
          alu_grant = ~mem_older_q;
        end else begin
          mem_grant = (last_grant_q == GRANT_ALU);
          alu_grant = (last_grant_q == GRANT_MEM);
        end
      end
      default: ;
    endcase
    alu_ready = ~state_q[1] | alu_grant;
    mem_ready = ~state_q[0] | mem_grant;
  end

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.wb_w      = wb_w_q;
  assign bus.wb_sel    = wb_sel_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.stall_cnt = stall_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random contention,
// with per-requester expected queues checked against every write.
module tb_wb_port_arbiter;
  logic sysclk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [10:0] alu_exp_q[$];
  logic [10:0] mem_exp_q[$];
  logic [11:0] obs_q[$];
  logic [10:0] exp_v;

  wb_port_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

  wb_port_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard: each write port pulse must match the oldest accepted beat
  // of the requester it selects.
  always @(negedge sysclk) begin
    if (reset_n && bus.wb_w) begin
      obs_q.push_back({bus.wb_sel, bus.wb_addr, bus.wb_data});
      checks++;
      if (bus.wb_sel) begin
        if (mem_exp_q.size() == 0) begin
          errors++;
          $display("FAIL mem_write unexpected got %h", {bus.wb_addr, bus.wb_data});
        end else begin
          exp_v = mem_exp_q.pop_front();
          if ({bus.wb_addr, bus.wb_data} !== exp_v) begin
            errors++;
            $display("FAIL mem_write got %h exp %h", {bus.wb_addr, bus.wb_data}, exp_v);
          end
        end
      end else begin
        if (alu_exp_q.size() == 0) begin
          errors++;
          $display("FAIL alu_write unexpected got %h", {bus.wb_addr, bus.wb_data});
        end else begin
          exp_v = alu_exp_q.pop_front();
          if ({bus.wb_addr, bus.wb_data} !== exp_v) begin
            errors++;
            $display("FAIL alu_write got %h exp %h", {bus.wb_addr, bus.wb_data}, exp_v);
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    repeat (2) @(negedge sysclk);
    alu_exp_q.delete(); mem_exp_q.delete(); obs_q.delete();
    reset_n = 1'b1;
    @(negedge sysclk);
  endtask

  // Offer one beat per requester across the next rising edge.
  task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic mv, input logic [2:0] ma, input logic [7:0] md);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    if (av && bus.alu_ready) alu_exp_q.push_back({aa, ad});
    if (mv && bus.mem_ready) mem_exp_q.push_back({ma, md});
    @(negedge sysclk);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    for (int k = 0; k < 20 && obs_q.size() < n; k++) begin
      @(negedge sysclk);
      #1;
    end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL write_count got %0d exp %0d", obs_q.size(), n);
      $display("FAIL aborting: writes missing");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "missing writes");
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.stall_cnt, bus.alu_ready, bus.mem_ready}
        !== {1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got w=%b sel=%b a=%h d=%h st=%0d ar=%b mr=%b exp all 0 ready 1",
               bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.stall_cnt, bus.alu_ready, bus.mem_ready);
    end
    drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h33);
    checks++;
    if ({bus.wb_w, bus.stall_cnt, bus.dbg_state} !== {1'b1, 8'd1, 2'b11}) begin
      errors++;
      $display("FAIL midrun_busy got w=%b st=%0d state=%b exp 1 1 11", bus.wb_w, bus.stall_cnt, bus.dbg_state);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.stall_cnt, bus.dbg_state}
        !== {1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 2'b00}) begin
      errors++;
      $display("FAIL async_reset got w=%b sel=%b a=%h d=%h st=%0d state=%b exp zeros",
               bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.stall_cnt, bus.dbg_state);
    end
    alu_exp_q.delete(); mem_exp_q.delete();
    repeat (2) @(negedge sysclk);
    reset_n = 1'b1;
    #1;
    checks++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b11) begin
      errors++;
      $display("FAIL ready_after_reset got %b exp 11", {bus.alu_ready, bus.mem_ready});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge sysclk);
      checks++;
      if (bus.wb_w !== 1'b0) begin
        errors++;
        $display("FAIL no_write_after_reset got %b exp 0", bus.wb_w);
      end
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
    checks++;
    if (bus.wb_w !== 1'b0) begin
      errors++;
      $display("FAIL single_early got %b exp 0", bus.wb_w);
    end
    @(negedge sysclk);
    checks++;
    if ({bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data} !== {1'b1, 1'b0, 3'd3, 8'h5A}) begin
      errors++;
      $display("FAIL single_write got %b %b %h %h exp 1 0 3 5a", bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data);
    end
    @(negedge sysclk);
    checks++;
    if ({bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.alu_ready, bus.mem_ready}
        !== {1'b0, 1'b0, 3'd3, 8'h5A, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_hold got %b %b %h %h r=%b%b exp 0 0 3 5a r=11",
               bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.alu_ready, bus.mem_ready);
    end
  endtask

  task automatic test_simul_diff();
    do_reset();
    drive(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22);
    checks++;
    if ({bus.alu_ready, bus.mem_ready, bus.dbg_state} !== {1'b0, 1'b1, 2'b11}) begin
      errors++;
      $display("FAIL simul_ready got ar=%b mr=%b state=%b exp 0 1 11", bus.alu_ready, bus.mem_ready, bus.dbg_state);
    end
    @(negedge sysclk);
    checks++;
    if ({bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.stall_cnt} !== {1'b1, 1'b1, 3'd2, 8'h22, 8'd1}) begin
      errors++;
      $display("FAIL simul_first got %b %b %h %h st=%0d exp 1 1 2 22 st=1",
               bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.stall_cnt);
    end
    @(negedge sysclk);
    checks++;
    if ({bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.stall_cnt} !== {1'b1, 1'b0, 3'd1, 8'h11, 8'd1}) begin
      errors++;
      $display("FAIL simul_second got %b %b %h %h st=%0d exp 1 0 1 11 st=1",
               bus.wb_w, bus.wb_sel, bus.wb_addr, bus.wb_data, bus.stall_cnt);
    end
    @(negedge sysclk);
    checks++;
    if (bus.wb_w !== 1'b0) begin
      errors++;
      $display("FAIL simul_done got %b exp 0", bus.wb_w);
    end
  endtask

  task automatic test_same_addr_alu_older();
    logic [11:0] exp_seq [3];
    exp_seq[0] = {1'b1, 3'd6, 8'h66};
    exp_seq[1] = {1'b0, 3'd4, 8'hAA};
    exp_seq[2] = {1'b1, 3'd4, 8'hBB};
    do_reset();
    drive(1'b1, 3'd4, 8'hAA, 1'b1, 3'd6, 8'h66);
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'hBB);
    wait_writes(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL alu_older_order[%0d] got %h exp %h", i, obs_q[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_age_override();
    logic [11:0] exp_seq [3];
    exp_seq[0] = {1'b1, 3'd5, 8'h55};
    exp_seq[1] = {1'b1, 3'd7, 8'h72};
    exp_seq[2] = {1'b0, 3'd7, 8'h71};
    do_reset();
    drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h55);
    wait_writes(1);
    @(negedge sysclk);
    drive(1'b1, 3'd7, 8'h71, 1'b1, 3'd7, 8'h72);
    wait_writes(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_q[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL mem_older_order[%0d] got %h exp %h", i, obs_q[i], exp_seq[i]);
      end
    end
  endtask

  // Both requesters always valid; a beat not accepted is re-offered unchanged.
  task automatic run_contention(input int n, input bit strict);
    logic        a_pend = 1'b0, m_pend = 1'b0, a_rdy, m_rdy, last_sel = 1'b0;
    logic [10:0] a_item = '0, m_item = '0;
    int          exp_st;
    do_reset();
    for (int i = 0; i < n; i++) begin
      exp_st = (i - 1 > 255) ? 255 : i - 1;
      if (strict && i >= 2) begin
        checks++;
        if (bus.wb_w !== 1'b1) begin
          errors++;
          $display("FAIL contend_wb_w cycle %0d got %b exp 1", i, bus.wb_w);
        end
        checks++;
        if (bus.alu_ready === bus.mem_ready) begin
          errors++;
          $display("FAIL contend_ready cycle %0d got ar=%b mr=%b exp opposite", i, bus.alu_ready, bus.mem_ready);
        end
        checks++;
        if (bus.stall_cnt !== exp_st[7:0]) begin
          errors++;
          $display("FAIL contend_stall cycle %0d got %0d exp %0d", i, bus.stall_cnt, exp_st);
        end
      end
      if (strict && i >= 3) begin
        checks++;
        if (bus.wb_sel === last_sel) begin
          errors++;
          $display("FAIL contend_alternate cycle %0d got sel=%b exp %b", i, bus.wb_sel, ~last_sel);
        end
      end
      if (!strict && (i == 100 || i == 256 || i == n - 1)) begin
        checks++;
        if (bus.stall_cnt !== exp_st[7:0]) begin
          errors++;
          $display("FAIL stall_sat cycle %0d got %0d exp %0d", i, bus.stall_cnt, exp_st);
        end
      end
      last_sel = bus.wb_sel;
      if (!a_pend) a_item = 11'($urandom_range(0, 2047));
      if (!m_pend) m_item = 11'($urandom_range(0, 2047));
      a_rdy = bus.alu_ready;
      m_rdy = bus.mem_ready;
      drive(1'b1, a_item[10:8], a_item[7:0], 1'b1, m_item[10:8], m_item[7:0]);
      a_pend = ~a_rdy;
      m_pend = ~m_rdy;
    end
    for (int k = 0; k < 10 && (alu_exp_q.size() != 0 || mem_exp_q.size() != 0); k++)
      @(negedge sysclk);
    checks++;
    if (alu_exp_q.size() != 0 || mem_exp_q.size() != 0) begin
      errors++;
      $display("FAIL contend_drain got pending alu=%0d mem=%0d exp 0 0", alu_exp_q.size(), mem_exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    run_contention(20, 1'b1);
  endtask

  task automatic test_saturation();
    run_contention(300, 1'b0);
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    test_reset();
    test_single_alu();
    test_simul_diff();
    test_same_addr_alu_older();
    test_age_override();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
